// File: rtl/div_iter_if.sv
// div_iter_if: operand/result handshake bundle for the iterative divider.
//   Parameter W: divisor/quotient/remainder width. The dividend is 2W bits wide.
//   Request side : in_valid, in_ready, x (2W), d (W), sgn (DIV_SIGNED_EN builds only)
//   Response side: out_valid, out_ready, q (W), r (W), dz, ovf
//   Modports: master = operand source / result consumer, slave = divider.
//   Optional macro: DIV_SIGNED_EN adds the sgn signal.
// Handshake rule (both sides): a transfer happens on a rising clock edge
// where valid and ready are both 1. A source must hold its valid and payload
// stable until that edge. Ready may depend on state but never on valid.
interface div_iter_if #(parameter int W = 32);
  logic         in_valid;
  logic         in_ready;
  logic [2*W-1:0] x;
  logic [W-1:0] d;
`ifdef DIV_SIGNED_EN
  logic         sgn;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         dz;
  logic         ovf;

`ifdef DIV_SIGNED_EN
  modport master (output in_valid, x, d, sgn, out_ready,
                  input  in_ready, out_valid, q, r, dz, ovf);
  modport slave  (input  in_valid, x, d, sgn, out_ready,
                  output in_ready, out_valid, q, r, dz, ovf);
`else
  modport master (output in_valid, x, d, out_ready,
                  input  in_ready, out_valid, q, r, dz, ovf);
  modport slave  (input  in_valid, x, d, out_ready,
                  output in_ready, out_valid, q, r, dz, ovf);
`endif
endinterface

// File: rtl/div_iter.sv
// div_iter: iterative restoring divider, 2W-bit dividend / W-bit divisor
// giving a W-bit quotient and W-bit remainder, S quotient bits per clock.
//   Parameters: W (default 32), S (default 1), with 1 <= S <= W and W % S == 0.
//   Ports:
//     clk       rising-edge clock
//     rst_n     asynchronous active-low reset
//     bus       div_iter_if.slave (operands in, results out, valid/ready each side)
//     dbg_state FSM state (0 IDLE, 1 BUSY, 2 DONE)
//   Optional macro: DIV_SIGNED_EN adds two's-complement support selected by bus.sgn.
// Flow: IDLE accepts operands. Divide-by-zero and an oversized quotient go
// straight to DONE. Otherwise BUSY runs for W/S cycles. DONE holds the result
// until out_ready is sampled high.
module div_iter #(
  parameter int W = 32,
  parameter int S = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  div_iter_if.slave  bus,
  output logic [1:0] dbg_state
);

  localparam int N  = W / S;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (S < 1 || S > W || (W % S) != 0) begin : g_bad_param
      $error("div_iter: S must satisfy 1 <= S <= W and W %% S == 0");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [2*W-1:0]  work_q, work_d;
  logic [W-1:0]    d_q, d_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    q_q, q_d, r_q, r_d;
  logic            dz_q, dz_d, ovf_q, ovf_d;

  // Operand magnitudes. Unsigned builds pass the operands straight through.
  logic [2*W-1:0]  x_mag;
  logic [W-1:0]    d_mag;
`ifdef DIV_SIGNED_EN
  logic            x_neg, d_neg;
  logic            neg_q_q, neg_q_d, neg_r_q, neg_r_d, sgn_q, sgn_d;
  logic [W-1:0]    x_lo_q, x_lo_d;
  always_comb begin
    x_neg = bus.sgn & bus.x[2*W-1];
    d_neg = bus.sgn & bus.d[W-1];
    x_mag = x_neg ? (~bus.x + 1'b1) : bus.x;
    d_mag = d_neg ? (~bus.d + 1'b1) : bus.d;
  end
`else
  always_comb begin
    x_mag = bus.x;
    d_mag = bus.d;
  end
`endif

  // S chained restoring steps. The remainder half of work is always below d,
  // so one subtract of d shifted up by W bits decides each quotient bit.
  logic [2*W:0]    t;
  logic [2*W-1:0]  work_step;
  always_comb begin
    work_step = work_q;
    t         = '0;
    for (int i = 0; i < S; i++) begin
      t = {work_step, 1'b0} - {1'b0, d_q, {W{1'b0}}};
      if (!t[2*W])
        work_step = t[2*W-1:0] | {{(2*W-1){1'b0}}, 1'b1};
      else
        work_step = {work_step[2*W-2:0], 1'b0};
    end
  end

  // Final result formatting when the last BUSY step retires.
  logic [W-1:0] q_mag, r_mag, q_fin, r_fin;
  logic         fin_ovf;
  always_comb begin
    q_mag = work_step[W-1:0];
    r_mag = work_step[2*W-1:W];
`ifdef DIV_SIGNED_EN
    // A negative quotient may reach -2^(W-1). A positive one tops out at 2^(W-1)-1.
    if (!sgn_q)
      fin_ovf = 1'b0;
    else if (neg_q_q)
      fin_ovf = q_mag > {1'b1, {(W-1){1'b0}}};
    else
      fin_ovf = q_mag[W-1];
    q_fin = fin_ovf ? {W{1'b1}} : (neg_q_q ? (~q_mag + 1'b1) : q_mag);
    r_fin = fin_ovf ? x_lo_q    : (neg_r_q ? (~r_mag + 1'b1) : r_mag);
`else
    fin_ovf = 1'b0;
    q_fin   = q_mag;
    r_fin   = r_mag;
`endif
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
`ifdef DIV_SIGNED_EN
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    sgn_d   = sgn_q;
    x_lo_d  = x_lo_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.d == '0) begin
            state_d = DONE;
            dz_d    = 1'b1;
            ovf_d   = 1'b0;
            q_d     = {W{1'b1}};
            r_d     = bus.x[W-1:0];
          end else if (x_mag[2*W-1:W] >= d_mag) begin
            state_d = DONE;
            dz_d    = 1'b0;
            ovf_d   = 1'b1;
            q_d     = {W{1'b1}};
            r_d     = bus.x[W-1:0];
          end else begin
            state_d = BUSY;
            cnt_d   = '0;
            work_d  = x_mag;
            d_d     = d_mag;
`ifdef DIV_SIGNED_EN
            neg_q_d = x_neg ^ d_neg;
            neg_r_d = x_neg;
            sgn_d   = bus.sgn;
            x_lo_d  = bus.x[W-1:0];
`endif
          end
        end
      end
      BUSY: begin
        work_d = work_step;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
          q_d     = q_fin;
          r_d     = r_fin;
          dz_d    = 1'b0;
          ovf_d   = fin_ovf;
        end
      end
      DONE: begin
        if (bus.out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      sgn_q   <= 1'b0;
      x_lo_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
`ifdef DIV_SIGNED_EN
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      sgn_q   <= sgn_d;
      x_lo_q  <= x_lo_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.q         = q_q;
  assign bus.r         = r_q;
  assign bus.dz        = dz_q;
  assign bus.ovf       = ovf_q;
  assign dbg_state     = state_q;

endmodule
